// File: rtl/vertex_accum_buffer.sv
// Per-lane (vertex id, partial sum) circular FIFOs between the vertex units and the
// output-SRAM arbiter, with optional same-id accumulation into the tail entry.
module vertex_accum_buffer #(
  parameter int NUM_LANES    = 4,
  parameter int DEPTH        = 8,
  parameter int DATA_W       = 16,
  parameter int VID_W        = 8,
  parameter int DRAIN_THRESH = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_LANES-1:0]        in_valid,
  input  logic [NUM_LANES*VID_W-1:0]  in_vid,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  output logic [NUM_LANES-1:0]        in_ready,
  input  logic                        accum_en,
  input  logic                        flush,
  output logic [NUM_LANES-1:0]        req,
  output logic [NUM_LANES*VID_W-1:0]  req_vid,
  output logic [NUM_LANES*DATA_W-1:0] req_data,
  input  logic [NUM_LANES-1:0]        req_grant,
  output logic [NUM_LANES-1:0]        sat_flag,
  output logic                        busy,
  output logic                        empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {FILL, DRAIN} state_t;

  logic [NUM_LANES-1:0] lane_nonempty;
  logic [NUM_LANES-1:0] lane_draining;
  logic [NUM_LANES-1:0] lane_flush_pend;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [VID_W-1:0]  vid_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, tail_ptr, wr_ptr_inc, rd_ptr_inc;
    logic [CNT_W-1:0]  count, count_nxt;
    state_t            state, state_nxt;
    logic              flush_pend, sat_q;
    logic [VID_W-1:0]  lane_vid;
    logic [DATA_W-1:0] lane_data;
    logic              ready, accept, pop, merge, push, lane_req, ovf;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] merged;

    assign lane_vid  = in_vid[l*VID_W +: VID_W];
    assign lane_data = in_data[l*DATA_W +: DATA_W];

    assign tail_ptr   = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - 1'b1;
    assign wr_ptr_inc = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_inc = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    assign ready  = (count < CNT_W'(DEPTH)) & ~flush_pend;
    assign accept = in_valid[l] & ready;
    assign pop    = lane_req & req_grant[l];
    // A lone entry leaving this cycle cannot absorb the input; it becomes a new entry.
    assign merge  = accept & accum_en & (count != '0) & (vid_mem[tail_ptr] == lane_vid)
                    & ~((count == CNT_W'(1)) & pop);
    assign push   = accept & ~merge;

    assign sum    = {data_mem[tail_ptr][DATA_W-1], data_mem[tail_ptr]}
                    + {lane_data[DATA_W-1], lane_data};
    assign ovf    = sum[DATA_W] ^ sum[DATA_W-1];
    assign merged = ovf ? (sum[DATA_W] ? SAT_MIN : SAT_MAX) : sum[DATA_W-1:0];

    always_comb begin
      count_nxt = count;
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          vid_mem[i]  <= '0;
          data_mem[i] <= '0;
        end
      end else if (push) begin
        vid_mem[wr_ptr]  <= lane_vid;
        data_mem[wr_ptr] <= lane_data;
      end else if (merge) begin
        data_mem[tail_ptr] <= merged;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        flush_pend <= 1'b0;
        sat_q      <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr_inc;
        if (pop)  rd_ptr <= rd_ptr_inc;
        count <= count_nxt;
        if (merge && ovf) sat_q <= 1'b1;
        if (flush && !flush_pend)
          flush_pend <= 1'b1;
        else if (state == DRAIN && count == '0)
          flush_pend <= 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FILL;
      else        state <= state_nxt;
    end

    always_comb begin
      state_nxt = state;
      case (state)
        FILL:    if (count_nxt >= CNT_W'(DRAIN_THRESH) || flush_pend) state_nxt = DRAIN;
        DRAIN:   if (count == '0 && !flush_pend) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end

    always_comb begin
      lane_req = 1'b0;
      if (state == DRAIN) lane_req = (count != '0);
    end

    assign in_ready[l]                   = ready;
    assign req[l]                        = lane_req;
    assign req_vid[l*VID_W +: VID_W]     = vid_mem[rd_ptr];
    assign req_data[l*DATA_W +: DATA_W]  = data_mem[rd_ptr];
    assign sat_flag[l]                   = sat_q;
    assign lane_nonempty[l]              = (count != '0);
    assign lane_draining[l]              = (state == DRAIN);
    assign lane_flush_pend[l]            = flush_pend;
  end

  assign busy  = |(lane_nonempty | lane_draining);
  assign empty = ~|lane_nonempty & ~|lane_flush_pend;

endmodule
